// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline register slices: WB control bit
// positions, opcode width and the packed payload width helper.
package mips_pipe_pkg;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_JAL      = 2;
   localparam int OPCODE_W      = 6;
   localparam int OCC_W         = 4;

   // Payload is {ctrl, opcode, alu_result, rd_data, rd, pc_4}.
   function automatic int bundle_width(input int data_w, input int rd_w, input int ctrl_w);
      return ctrl_w + OPCODE_W + 3 * data_w + rd_w;
   endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// Two-entry skid register (main + skid) with valid/ready on both sides.
// in_ready is a flop, so there is no combinational path from out_ready.
module pipe_skid_slice #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid;
   logic         skid_valid;
   logic         ready_q;
   logic [W-1:0] main_data;
   logic [W-1:0] skid_data;

   logic         main_valid_nx;
   logic         skid_valid_nx;
   logic         load_main_in;
   logic         load_main_skid;
   logic         load_skid;
   logic         accept;
   logic         drain;

   always_comb begin
      accept         = in_valid & ready_q & ~flush;
      drain          = main_valid & out_ready;
      main_valid_nx  = main_valid;
      skid_valid_nx  = skid_valid;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         main_valid_nx = 1'b0;
         skid_valid_nx = 1'b0;
      end else if (skid_valid) begin
         // ready_q is low here, so no accept can coincide with the skid refill
         if (drain) begin
            load_main_skid = 1'b1;
            skid_valid_nx  = 1'b0;
         end
      end else if (!main_valid || drain) begin
         main_valid_nx = accept;
         load_main_in  = accept;
      end else if (accept) begin
         skid_valid_nx = 1'b1;
         load_skid     = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         main_valid <= main_valid_nx;
         skid_valid <= skid_valid_nx;
         ready_q    <= ~skid_valid_nx;
         if (load_main_in) begin
            main_data <= in_data;
         end else if (load_main_skid) begin
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_data <= in_data;
         end
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: DEPTH cascaded skid slices carrying the WB bundle,
// with a registered occupancy count and write-enable gating for the WB stage.
module mem_wb_pipe
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 3,
   parameter int DEPTH  = 1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CTRL_W-1:0]   in_ctrl,
   input  logic [OPCODE_W-1:0] in_opcode,
   input  logic [DATA_W-1:0]   in_alu_result,
   input  logic [DATA_W-1:0]   in_rd_data,
   input  logic [RD_W-1:0]     in_rd,
   input  logic [DATA_W-1:0]   in_pc_4,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CTRL_W-1:0]   out_ctrl,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [DATA_W-1:0]   out_alu_result,
   output logic [DATA_W-1:0]   out_rd_data,
   output logic [RD_W-1:0]     out_rd,
   output logic [DATA_W-1:0]   out_pc_4,
   output logic                wb_reg_write,
   output logic [OCC_W-1:0]    occupancy
);

   localparam int PAY_W = bundle_width(DATA_W, RD_W, CTRL_W);

   if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
      $error("mem_wb_pipe: DEPTH must be in 1..4");
   end

   logic [DEPTH:0]            chain_valid;
   logic [DEPTH:0]            chain_ready;
   logic [DEPTH:0][PAY_W-1:0] chain_data;

   assign chain_valid[0] = in_valid;
   assign chain_data[0]  = {in_ctrl, in_opcode, in_alu_result, in_rd_data, in_rd, in_pc_4};
   assign in_ready       = chain_ready[0];

   for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      pipe_skid_slice #(.W(PAY_W)) u_slice (
         .CLK       (CLK),
         .RESET_N   (RESET_N),
         .flush     (flush),
         .in_valid  (chain_valid[i]),
         .in_ready  (chain_ready[i]),
         .in_data   (chain_data[i]),
         .out_valid (chain_valid[i+1]),
         .out_ready (chain_ready[i+1]),
         .out_data  (chain_data[i+1])
      );
   end

   assign chain_ready[DEPTH] = out_ready;
   assign out_valid          = chain_valid[DEPTH];
   assign {out_ctrl, out_opcode, out_alu_result, out_rd_data, out_rd, out_pc_4} = chain_data[DEPTH];

   assign wb_reg_write = out_valid & out_ready & out_ctrl[CTRL_REGWRITE];

   logic             accept_top;
   logic             drain_top;
   logic [OCC_W-1:0] occ_q;

   assign accept_top = in_valid & in_ready & ~flush;
   assign drain_top  = out_valid & out_ready;

   // Internal slice-to-slice moves never change the total held count.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else begin
         case ({accept_top, drain_top})
            2'b10:   occ_q <= occ_q + 4'd1;
            2'b01:   occ_q <= occ_q - 4'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a DEPTH=1 and a DEPTH=2 instance share
// stimulus; each scenario resets first and checks only the relevant instance.
module tb_mem_wb_pipe;

   logic        CLK;
   logic        RESET_N;
   logic        in_valid;
   logic [2:0]  in_ctrl;
   logic [5:0]  in_opcode;
   logic [31:0] in_alu_result;
   logic [31:0] in_rd_data;
   logic [4:0]  in_rd;
   logic [31:0] in_pc_4;
   logic        flush;
   logic        out_ready;

   logic        d1_in_ready, d1_out_valid, d1_wb;
   logic [2:0]  d1_ctrl;
   logic [5:0]  d1_opcode;
   logic [31:0] d1_alu, d1_rd_data, d1_pc_4;
   logic [4:0]  d1_rd;
   logic [3:0]  d1_occ;

   logic        d2_in_ready, d2_out_valid, d2_wb;
   logic [2:0]  d2_ctrl;
   logic [5:0]  d2_opcode;
   logic [31:0] d2_alu, d2_rd_data, d2_pc_4;
   logic [4:0]  d2_rd;
   logic [3:0]  d2_occ;

   int checks = 0;
   int errors = 0;

   mem_wb_pipe #(.DATA_W(32), .RD_W(5), .CTRL_W(3), .DEPTH(1)) dut1 (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_ctrl(in_ctrl), .in_opcode(in_opcode), .in_alu_result(in_alu_result),
      .in_rd_data(in_rd_data), .in_rd(in_rd), .in_pc_4(in_pc_4), .flush(flush),
      .out_valid(d1_out_valid), .out_ready(out_ready), .out_ctrl(d1_ctrl),
      .out_opcode(d1_opcode), .out_alu_result(d1_alu), .out_rd_data(d1_rd_data),
      .out_rd(d1_rd), .out_pc_4(d1_pc_4), .wb_reg_write(d1_wb), .occupancy(d1_occ)
   );

   mem_wb_pipe #(.DATA_W(32), .RD_W(5), .CTRL_W(3), .DEPTH(2)) dut2 (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_ctrl(in_ctrl), .in_opcode(in_opcode), .in_alu_result(in_alu_result),
      .in_rd_data(in_rd_data), .in_rd(in_rd), .in_pc_4(in_pc_4), .flush(flush),
      .out_valid(d2_out_valid), .out_ready(out_ready), .out_ctrl(d2_ctrl),
      .out_opcode(d2_opcode), .out_alu_result(d2_alu), .out_rd_data(d2_rd_data),
      .out_rd(d2_rd), .out_pc_4(d2_pc_4), .wb_reg_write(d2_wb), .occupancy(d2_occ)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [2:0]  ctrl;
      logic [31:0] alu;
      logic        chk_wb;
      logic        exp_wb;
      logic        exp_ov;
      logic [31:0] exp_alu;
      logic        exp_ir;
      logic [3:0]  exp_occ;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                               input logic [2:0] ctrl, input logic [31:0] alu,
                               input logic chk_wb, input logic exp_wb, input logic exp_ov,
                               input logic [31:0] exp_alu, input logic exp_ir,
                               input logic [3:0] exp_occ);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl; v.alu = alu;
      v.chk_wb = chk_wb; v.exp_wb = exp_wb; v.exp_ov = exp_ov;
      v.exp_alu = exp_alu; v.exp_ir = exp_ir; v.exp_occ = exp_occ;
      return v;
   endfunction

   vec_t tbl [14];

   task automatic do_reset();
      @(negedge CLK);
      RESET_N   = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   initial begin
      // DEPTH=1: back-pressure, write gating, then flush collision at occupancy 2
      //             iv ordy fl ctrl    alu  cwb ewb ov  ealu ir occ
      tbl[0]  = mk(1, 0, 0, 3'b001, 1,  1, 0, 1, 1,  1, 1);
      tbl[1]  = mk(1, 0, 0, 3'b001, 2,  1, 0, 1, 1,  0, 2);
      tbl[2]  = mk(1, 0, 0, 3'b001, 3,  1, 0, 1, 1,  0, 2);
      tbl[3]  = mk(0, 1, 0, 3'b001, 0,  1, 1, 1, 2,  1, 1);
      tbl[4]  = mk(0, 0, 0, 3'b001, 0,  1, 0, 1, 2,  1, 1);
      tbl[5]  = mk(0, 1, 0, 3'b001, 0,  1, 1, 0, 2,  1, 0);
      tbl[6]  = mk(1, 1, 0, 3'b110, 9,  1, 0, 1, 9,  1, 1);
      tbl[7]  = mk(1, 1, 0, 3'b001, 10, 1, 0, 1, 10, 1, 1);
      tbl[8]  = mk(0, 0, 0, 3'b001, 0,  1, 0, 1, 10, 1, 1);
      tbl[9]  = mk(0, 1, 0, 3'b001, 0,  1, 1, 0, 10, 1, 0);
      tbl[10] = mk(1, 0, 0, 3'b001, 11, 1, 0, 1, 11, 1, 1);
      tbl[11] = mk(1, 0, 0, 3'b001, 12, 1, 0, 1, 11, 0, 2);
      tbl[12] = mk(1, 1, 1, 3'b001, 13, 0, 0, 0, 11, 1, 0);
      tbl[13] = mk(0, 1, 0, 3'b001, 0,  1, 0, 0, 11, 1, 0);

      RESET_N       = 1'b0;
      in_valid      = 1'b1;
      in_ctrl       = 3'b001;
      in_opcode     = 6'h23;
      in_alu_result = 32'h55;
      in_rd_data    = 32'hA5A5;
      in_rd         = 5'd7;
      in_pc_4       = 32'h100;
      flush         = 1'b0;
      out_ready     = 1'b1;

      // Reset held with in_valid asserted
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         chk("rst_d1_out_valid", {31'b0, d1_out_valid}, 32'd0);
         chk("rst_d2_out_valid", {31'b0, d2_out_valid}, 32'd0);
         chk("rst_d1_occ", {28'b0, d1_occ}, 32'd0);
         chk("rst_d2_occ", {28'b0, d2_occ}, 32'd0);
         chk("rst_d1_in_ready", {31'b0, d1_in_ready}, 32'd1);
         chk("rst_d2_in_ready", {31'b0, d2_in_ready}, 32'd1);
         chk("rst_d1_wb", {31'b0, d1_wb}, 32'd0);
         chk("rst_d2_alu", d2_alu, 32'd0);
      end
      @(negedge CLK);
      RESET_N  = 1'b1;
      in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge CLK); #1;
         chk("post_rst_d1_out_valid", {31'b0, d1_out_valid}, 32'd0);
         chk("post_rst_d2_out_valid", {31'b0, d2_out_valid}, 32'd0);
         chk("post_rst_d2_occ", {28'b0, d2_occ}, 32'd0);
      end

      // Table-driven DEPTH=1 sequence
      for (int i = 0; i < 14; i++) begin
         @(negedge CLK);
         in_valid      = tbl[i].iv;
         out_ready     = tbl[i].ordy;
         flush         = tbl[i].fl;
         in_ctrl       = tbl[i].ctrl;
         in_alu_result = tbl[i].alu;
         #1;
         if (tbl[i].chk_wb) chk($sformatf("v%0d_wb", i), {31'b0, d1_wb}, {31'b0, tbl[i].exp_wb});
         @(posedge CLK); #1;
         chk($sformatf("v%0d_out_valid", i), {31'b0, d1_out_valid}, {31'b0, tbl[i].exp_ov});
         chk($sformatf("v%0d_alu", i), d1_alu, tbl[i].exp_alu);
         chk($sformatf("v%0d_in_ready", i), {31'b0, d1_in_ready}, {31'b0, tbl[i].exp_ir});
         chk($sformatf("v%0d_occ", i), {28'b0, d1_occ}, {28'b0, tbl[i].exp_occ});
         if (tbl[i].exp_ov) chk($sformatf("v%0d_rd", i), {27'b0, d1_rd}, 32'd7);
      end

      // DEPTH=2 streaming: value j appears after edge j, bundle fields together
      do_reset();
      in_ctrl = 3'b001;
      for (int j = 0; j < 11; j++) begin
         @(negedge CLK);
         out_ready     = 1'b1;
         in_valid      = (j < 8);
         in_alu_result = j + 1;
         in_pc_4       = (j + 1) * 4;
         @(posedge CLK); #1;
         if (j >= 1 && j <= 8) begin
            chk($sformatf("stream%0d_valid", j), {31'b0, d2_out_valid}, 32'd1);
            chk($sformatf("stream%0d_alu", j), d2_alu, j);
            chk($sformatf("stream%0d_pc4", j), d2_pc_4, j * 4);
         end else begin
            chk($sformatf("stream%0d_valid", j), {31'b0, d2_out_valid}, 32'd0);
         end
      end

      // DEPTH=2 async reset mid-stream at occupancy 3
      do_reset();
      for (int j = 0; j < 3; j++) begin
         @(negedge CLK);
         out_ready     = 1'b0;
         in_valid      = 1'b1;
         in_alu_result = 21 + j;
         @(posedge CLK); #1;
      end
      #1;
      chk("async_pre_occ", {28'b0, d2_occ}, 32'd3);
      chk("async_pre_valid", {31'b0, d2_out_valid}, 32'd1);
      chk("async_pre_alu", d2_alu, 32'd21);
      chk("async_pre_in_ready", {31'b0, d2_in_ready}, 32'd1);
      RESET_N = 1'b0;
      #1;
      chk("async_valid", {31'b0, d2_out_valid}, 32'd0);
      chk("async_occ", {28'b0, d2_occ}, 32'd0);
      chk("async_in_ready", {31'b0, d2_in_ready}, 32'd1);
      chk("async_alu", d2_alu, 32'd0);
      chk("async_d1_valid", {31'b0, d1_out_valid}, 32'd0);
      @(negedge CLK);
      in_valid = 1'b0;
      RESET_N  = 1'b1;
      @(posedge CLK); #1;
      chk("async_post_valid", {31'b0, d2_out_valid}, 32'd0);
      chk("async_post_occ", {28'b0, d2_occ}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
